// File: rtl/systolic_drain.sv
// Result drain: snapshots the NxN result matrix on a rising edge of i_done and streams it out one row per handshake.
// Optional sticky overrun flag for done edges dropped mid-stream: define SYSTOLIC_DRAIN_OVERRUN_EN.
module systolic_drain #(
  parameter  int W  = 32,
  parameter  int N  = 3,
  localparam int RW = $clog2(N)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_done,
  input  logic [W*N*N-1:0] i_C,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W*N-1:0]   o_data,
  output logic [RW-1:0]    o_row,
  output logic             o_last,
  output logic             o_busy
`ifdef SYSTOLIC_DRAIN_OVERRUN_EN
  ,
  input  logic             i_overrun_clr,
  output logic             o_overrun
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  state_t                      r_state, w_state_d;
  logic                        r_done_q;
  logic [N-1:0][W*N-1:0]       r_buf;
  logic                        r_valid;
  logic [W*N-1:0]              r_data;
  logic [RW-1:0]               r_row;
  logic                        r_last;
  logic                        w_rise, w_hs, w_final, w_cap;
  logic [RW-1:0]               w_row_d;
  logic [W*N-1:0]              w_data_d;

  assign w_rise  = i_done & ~r_done_q;
  assign w_hs    = r_valid & i_ready;
  assign w_final = w_hs & (r_row == LAST_ROW);
  // A new matrix is only taken when idle or exactly as the last row leaves.
  assign w_cap   = w_rise & ((r_state == S_IDLE) | w_final);

  always_comb begin
    w_state_d = r_state;
    w_row_d   = r_row;
    w_data_d  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_cap) begin
          w_state_d = S_STREAM;
          w_row_d   = '0;
        end
      end
      S_STREAM: begin
        if (w_cap) begin
          w_row_d = '0;
        end else if (w_final) begin
          w_state_d = S_IDLE;
          w_row_d   = '0;
        end else if (w_hs) begin
          w_row_d = r_row + 1'b1;
        end
      end
      default: begin
        w_state_d = S_IDLE;
        w_row_d   = '0;
      end
    endcase
    // Row 0 of a fresh capture comes straight from i_C since the buffer loads on the same edge.
    if (w_cap)
      w_data_d = i_C[W*N-1:0];
    else if (w_state_d == S_STREAM)
      w_data_d = r_buf[w_row_d];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_done_q <= 1'b0;
      r_buf    <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_row    <= '0;
      r_last   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_done_q <= i_done;
      r_valid  <= (w_state_d == S_STREAM);
      r_data   <= w_data_d;
      r_row    <= w_row_d;
      r_last   <= (w_state_d == S_STREAM) && (w_row_d == LAST_ROW);
      if (w_cap)
        r_buf <= i_C;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_row   = r_row;
  assign o_last  = r_last;
  assign o_busy  = (r_state == S_STREAM);

`ifdef SYSTOLIC_DRAIN_OVERRUN_EN
  logic r_overrun;

  // Set has priority over clear so a simultaneous drop is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_overrun <= 1'b0;
    else if (w_rise && (r_state == S_STREAM) && !w_final)
      r_overrun <= 1'b1;
    else if (i_overrun_clr)
      r_overrun <= 1'b0;
  end

  assign o_overrun = r_overrun;
`endif

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Result-side counterpart to the systolic operand sequencer: it collects the N×N result matrix and delivers it downstream.
- When the sequencer's done flag rises, the block snapshots the flat result bus from the systolic array into a local buffer.
- It then streams the matrix out one row per transfer over a valid/ready handshake, with row index and last-row markers.
- It sits between the systolic array/sequencer and downstream consumers (writeback, host interface).

Parameters:
- W, 32, element width in bits.
- N, 3, matrix dimension (N×N elements, N rows streamed); legal N >= 2.
- RW, $clog2(N), row-index width (localparam, derived).

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_done  input  1  result-ready level from the sequencer; stays high while the result holds.
- i_C  input  W*N*N  flat result matrix; element k at bits [(k+1)*W-1 : k*W], k = row*N + col.
- o_valid  output  1  o_data carries a valid row.
- i_ready  input  1  downstream accepts the row this cycle.
- o_data  output  W*N  current row; col c at bits [(c+1)*W-1 : c*W].
- o_row  output  RW  index of the row on o_data.
- o_last  output  1  high with o_valid when o_row == N-1.
- o_busy  output  1  high while a matrix is buffered and not fully drained.

Behaviour:
- Reset (i_rst_n low, async): state IDLE, o_valid=0, o_data=0, o_row=0, o_last=0, o_busy=0, buffer cleared, done_q=0.
- Edge detect: done_q registers i_done each cycle; done_rise = i_done & ~done_q. Only rising edges trigger capture. A level held high never retriggers.
- FSM states:
  - IDLE: outputs quiet. On done_rise, buffer <= i_C at that edge, row <= 0, go to STREAM.
  - STREAM: o_valid=1, o_busy=1, o_data = buffer row `row`, o_last = (row == N-1). On a handshake (o_valid & i_ready) with row < N-1, row increments. On a handshake with row == N-1, go to IDLE.
- Latency: the edge where done_rise is sampled high captures i_C. o_valid is high the next cycle with row 0. At one row per cycle with i_ready held high, the full matrix drains in N cycles after capture.
- Stability: while o_valid & ~i_ready, o_data, o_row and o_last hold constant. The buffer is never rewritten mid-stream, even if i_C changes.
- done_rise in STREAM, not on the final handshake: ignored, no recapture.
- done_rise on the same cycle as the final handshake (row N-1): recapture i_C, row <= 0, stay in STREAM. o_valid stays high with no bubble.
- i_ready high in IDLE: no effect. i_ready is not required before o_valid; o_valid never waits on i_ready.
- Reset asserted mid-stream: immediate return to reset values; the partially drained matrix is discarded.
- Data is passed through unmodified; no arithmetic or width change.
- o_valid, o_data, o_row and o_last are registered outputs, with no combinational path from i_ready.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_OVERRUN_EN.
- Defined:
  - Adds output o_overrun (1 bit, reset 0). It is set sticky on any done_rise ignored in STREAM, i.e. not coincident with the final handshake.
  - It is cleared only by reset or by a new input i_overrun_clr (1 bit). If set and clear occur in the same cycle, set wins.
- Undefined: neither port exists; ignored edges are silently dropped.

Test Plan:
- Capture and drain with i_ready=1: i_C elements k = 100+k, N=3, pulse i_done high → one cycle later o_valid=1 with rows {100,101,102}, {103,104,105}, {106,107,108} on consecutive cycles. o_row = 0,1,2; o_last only on row 2; o_valid=0 on the 4th cycle.
- Backpressure: i_ready=0 for 5 cycles after o_valid rises → o_data/o_row hold row 0 unchanged. Change i_C to all 0xFFFFFFFF during the stall → streamed rows still 100..108.
- Level hold: keep i_done high for 20 cycles → exactly one 3-row burst, then o_busy=0 and no further o_valid.
- Back-to-back: drop i_done, then raise it again so that done_rise coincides with the row-2 handshake, with i_C = 200+k → row 0 = {200,201,202} on the next cycle with no o_valid gap.
- Reset mid-stream: deassert i_rst_n asynchronously between edges while row 1 is pending → o_valid, o_busy, o_row and o_data are 0 immediately. After release, FSM is IDLE until the next done_rise.
- With SYSTOLIC_DRAIN_OVERRUN_EN: done_rise during row 0 with i_ready=0 → o_overrun=1 and stays 1 through the drain. Pulse i_overrun_clr → 0 next cycle. Assert clear and a new overrun in the same cycle → stays 1.
